// File: rtl/div_seq_ctrl.sv
// Iterative restoring divider for the EX stage: DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Holds the pipeline in stall until the result is ready; divide-by-zero and signed overflow finish in one cycle.
module div_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            stall_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] ONE      = XLEN'(1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_result;
    logic            r_is_rem;
    logic            r_qsign;
    logic            r_rsign;

    logic            w_accept;
    logic            w_signed;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_fix_res;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_sub;
    logic            w_fits;

    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] x);
        return ~x + ONE;
    endfunction

    function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] x, input logic is_signed);
        return (is_signed && x[XLEN-1]) ? f_neg(x) : x;
    endfunction

    assign w_accept   = (r_state == S_IDLE) && start_i && !kill_i;
    assign w_signed   = !op_i[0];
    assign w_div_zero = (b_i == '0);
    assign w_ovf      = w_signed && (a_i == MIN_NEG) && (b_i == '1);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = op_i[1] ? a_i : '1;
        else
            w_special_res = op_i[1] ? '0 : MIN_NEG;
    end

    // The partial remainder is always below the divisor, so bit XLEN of the
    // difference is a clean borrow: clear means the shifted remainder >= divisor.
    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_sub    = w_rem_sh - {1'b0, r_div};
    assign w_fits   = !w_sub[XLEN];

    assign w_fix_res = r_is_rem ? (r_rsign ? f_neg(r_rem) : r_rem)
                                : (r_qsign ? f_neg(r_quo) : r_quo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = w_special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (kill_i)
                    w_next = S_IDLE;
                else if (r_cnt == CNT_LAST)
                    w_next = S_FIX;
            end
            S_FIX:   w_next = kill_i ? S_IDLE : S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_is_rem <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= op_i[1];
                        r_qsign  <= w_signed && (a_i[XLEN-1] ^ b_i[XLEN-1]);
                        r_rsign  <= w_signed && a_i[XLEN-1];
                        r_div    <= f_abs(b_i, w_signed);
                        r_quo    <= f_abs(a_i, w_signed);
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        if (w_special)
                            r_result <= w_special_res;
                    end
                end
                S_CALC: begin
                    if (!kill_i) begin
                        r_rem <= w_fits ? w_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], w_fits};
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_FIX: begin
                    if (!kill_i)
                        r_result <= w_fix_res;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (r_state == S_CALC) || (r_state == S_FIX);
    assign done_o   = (r_state == S_DONE);
    assign result_o = r_result;
    assign stall_o  = w_accept || busy_o;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: stimulus pushes expected results, a monitor
// pops and compares on every done_o pulse, including result and latency.
module tb_div_seq_ctrl;

    localparam int XLEN = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_i = 1'b0;
    logic [1:0]      op_i = 2'b00;
    logic [XLEN-1:0] a_i = '0;
    logic [XLEN-1:0] b_i = '0;
    logic            kill_i = 1'b0;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic            stall_o;

    typedef struct {
        logic [XLEN-1:0] res;
        int              t0;
        int              lat;
        string           name;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    logic [XLEN-1:0] prev_res = '0;

    div_seq_ctrl #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .kill_i   (kill_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .stall_o  (stall_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%h expected=no_done", result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, result_o, e.res);
                chk({e.name, "_latency"}, XLEN'(cyc - e.t0 + 1), XLEN'(e.lat));
            end
        end
    end

    // Drive one request for a single cycle; returns just after the sampling edge.
    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge clk);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        #1 chk("stall_on_request", {31'b0, stall_o}, 32'd1);
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit stall_ok = 1'b1;
        int n = 0;
        forever begin
            @(negedge clk);
            if (done_o) break;
            if (!stall_o) stall_ok = 1'b0;
            n++;
            if (n > max_cyc) begin
                checks++;
                errors++;
                $display("FAIL done_timeout actual=none expected=done_within_%0d", max_cyc);
                return;
            end
        end
        chk("stall_low_in_done", {31'b0, stall_o}, 32'd0);
        chk("stall_high_while_busy", {31'b0, stall_ok}, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
        exp_t e;
        issue(op, a, b);
        e.res = exp; e.t0 = cyc; e.lat = lat; e.name = name;
        sb.push_back(e);
        prev_res = exp;
        wait_done(40);
    endtask

    initial begin
        #2;
        chk("reset_busy", {31'b0, busy_o}, 32'd0);
        chk("reset_done", {31'b0, done_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_stall", {31'b0, stall_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("divu_100_7",   OP_DIVU, 32'd100,      32'd7,        32'd14,       34);
        run_op("div_m7_2",     OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("rem_m7_2",     OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("div_20_m3",    OP_DIV,  32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 34);
        run_op("rem_20_m3",    OP_REM,  32'd20,       32'hFFFFFFFD, 32'd2,        34);
        run_op("divu_max_1",   OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34);
        run_op("remu_max_16",  OP_REMU, 32'hFFFFFFFF, 32'd16,       32'd15,       34);
        run_op("divu_min_max", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34);
        run_op("divu_by0",     OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("div_by0",      OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("remu_by0",     OP_REMU, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",      OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",      OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // kill in CALC: no done_o, back to IDLE, result held
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        kill_i = 1'b1;
        @(posedge clk);
        #1 kill_i = 1'b0;
        chk("kill_busy", {31'b0, busy_o}, 32'd0);
        chk("kill_result_held", result_o, prev_res);
        repeat (40) @(negedge clk);
        chk("kill_result_still_held", result_o, prev_res);
        run_op("after_kill", OP_DIVU, 32'd1000, 32'd3, 32'd333, 34);

        // start together with kill in IDLE is refused
        @(negedge clk);
        op_i = OP_DIVU; a_i = 32'd50; b_i = 32'd5; start_i = 1'b1; kill_i = 1'b1;
        #1 chk("kill_start_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1 start_i = 1'b0; kill_i = 1'b0;
        chk("kill_start_busy", {31'b0, busy_o}, 32'd0);
        repeat (3) @(negedge clk);

        // start pulses while busy are ignored; a start in the DONE cycle is not accepted
        begin
            exp_t e;
            issue(OP_DIVU, 32'd1000, 32'd7);
            e.res = 32'd142; e.t0 = cyc; e.lat = 34; e.name = "ignore_starts";
            sb.push_back(e);
            prev_res = 32'd142;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                op_i = OP_DIV; a_i = 32'(i + 77); b_i = 32'd2; start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
            wait_done(40);
            op_i = OP_DIVU; a_i = 32'd9; b_i = 32'd3; start_i = 1'b1;
            @(posedge clk);
            #1 start_i = 1'b0;
            chk("start_in_done_busy", {31'b0, busy_o}, 32'd0);
            repeat (40) @(negedge clk);
            chk("start_in_done_result", result_o, 32'd142);
        end

        // async reset mid-CALC
        issue(OP_DIVU, 32'd12345, 32'd11);
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op("after_rst", OP_REMU, 32'd12345, 32'd11, 32'd3, 34);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
